// File: rtl/scaler_frame_ctrl.sv
// Frame-level sequencer in front of the scaler_h -> scaler_v chain.
// Passes only whole input frames, swaps in a new scale step at frame start,
// measures input and scaler output frame sizes, and watches for a missing
// scaler output frame.
module scaler_frame_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int STEP       = 4096,
    parameter int STEP_MIN   = 1024,
    parameter int STEP_MAX   = 16384,
    parameter int TIMEOUT    = 1048576
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable_i,
    input  logic [15:0]           cfg_step_i,
    input  logic                  cfg_wr_i,
    output logic                  cfg_pend_o,
    output logic                  cfg_err_o,
    output logic [15:0]           scale_step_o,
    input  logic [DATA_WIDTH-1:0] di_i,
    input  logic                  de_i,
    input  logic                  hs_i,
    input  logic                  vs_i,
    output logic [DATA_WIDTH-1:0] do_o,
    output logic                  de_o,
    output logic                  hs_o,
    output logic                  vs_o,
    input  logic                  sc_de_i,
    input  logic                  sc_hs_i,
    input  logic                  sc_vs_i,
    output logic                  busy_o,
    output logic [15:0]           frame_cnt_o,
    output logic [15:0]           in_w_o,
    output logic [15:0]           in_h_o,
    output logic [15:0]           out_w_o,
    output logic [15:0]           out_h_o,
    output logic                  sc_timeout_o
);

    localparam int              WD_W     = $clog2(TIMEOUT + 1);
    localparam logic [15:0]     STEP_RST = 16'(STEP);
    localparam logic [15:0]     STEP_LO  = 16'(STEP_MIN);
    localparam logic [15:0]     STEP_HI  = 16'(STEP_MAX);
    localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

    state_t          state;
    state_t          next_state;
    logic            vs_d;
    logic            hs_d;
    logic            sc_vs_d;
    logic            sc_hs_d;
    logic            frame_start;
    logic            frame_end;
    logic            line_end;
    logic            sc_frame_end;
    logic            sc_line_end;
    logic            go_run;
    logic            pass;
    logic            cfg_ok;
    logic [15:0]     shadow;
    logic [15:0]     in_pix;
    logic [15:0]     in_wid;
    logic [15:0]     in_lines;
    logic [15:0]     sc_pix;
    logic [15:0]     sc_wid;
    logic [15:0]     sc_lines;
    logic            wd_armed;
    logic [WD_W-1:0] wd_cnt;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign frame_start  = vs_d & ~vs_i;
    assign frame_end    = ~vs_d & vs_i;
    assign line_end     = ~hs_d & hs_i;
    assign sc_frame_end = ~sc_vs_d & sc_vs_i;
    assign sc_line_end  = ~sc_hs_d & sc_hs_i;
    assign cfg_ok       = cfg_wr_i && (cfg_step_i >= STEP_LO) && (cfg_step_i <= STEP_HI);
    assign pass         = (state == RUN) || go_run;
    assign busy_o       = (state == RUN);

    // State register for the frame sequencer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state: enter RUN only on a vs fall seen while armed; leave RUN only at frame end.
    always_comb begin
        next_state = state;
        go_run     = 1'b0;
        case (state)
            IDLE: begin
                if (enable_i) next_state = ARM;
            end
            ARM: begin
                if (!enable_i) begin
                    next_state = IDLE;
                end else if (frame_start) begin
                    next_state = RUN;
                    go_run     = 1'b1;
                end
            end
            RUN: begin
                if (frame_end) next_state = enable_i ? ARM : IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Delayed copies of the sync inputs used for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_d    <= 1'b0;
            hs_d    <= 1'b0;
            sc_vs_d <= 1'b0;
            sc_hs_d <= 1'b0;
        end else begin
            vs_d    <= vs_i;
            hs_d    <= hs_i;
            sc_vs_d <= sc_vs_i;
            sc_hs_d <= sc_hs_i;
        end
    end

    // Registered video gate: pass the input while a frame is running, else force blank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            do_o <= '0;
            de_o <= 1'b0;
            hs_o <= 1'b1;
            vs_o <= 1'b1;
        end else begin
            do_o <= pass ? di_i : '0;
            de_o <= pass & de_i;
            hs_o <= pass ? hs_i : 1'b1;
            vs_o <= pass ? vs_i : 1'b1;
        end
    end

    // Step shadow/active pair; a write on the apply cycle lands after the apply.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scale_step_o <= STEP_RST;
            shadow       <= STEP_RST;
            cfg_pend_o   <= 1'b0;
            cfg_err_o    <= 1'b0;
            frame_cnt_o  <= 16'd0;
        end else begin
            cfg_err_o <= cfg_wr_i & ~cfg_ok;
            if (go_run) begin
                frame_cnt_o <= frame_cnt_o + 16'd1;
                if (cfg_pend_o) begin
                    scale_step_o <= shadow;
                    cfg_pend_o   <= 1'b0;
                end
            end
            if (cfg_ok) begin
                shadow     <= cfg_step_i;
                cfg_pend_o <= 1'b1;
            end
        end
    end

    // Input frame size, counted only while a frame is being passed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_pix   <= 16'd0;
            in_wid   <= 16'd0;
            in_lines <= 16'd0;
            in_w_o   <= 16'd0;
            in_h_o   <= 16'd0;
        end else if (state == RUN) begin
            if (frame_end) begin
                in_w_o   <= in_wid;
                in_h_o   <= in_lines;
                in_pix   <= 16'd0;
                in_wid   <= 16'd0;
                in_lines <= 16'd0;
            end else if (line_end) begin
                if (in_pix != 16'd0) begin
                    in_wid   <= in_pix;
                    in_lines <= sat_inc(in_lines);
                end
                in_pix <= 16'd0;
            end else if (de_i) begin
                in_pix <= sat_inc(in_pix);
            end
        end
    end

    // Scaler output frame size, always monitored regardless of sequencer state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sc_pix   <= 16'd0;
            sc_wid   <= 16'd0;
            sc_lines <= 16'd0;
            out_w_o  <= 16'd0;
            out_h_o  <= 16'd0;
        end else if (sc_frame_end) begin
            out_w_o  <= sc_wid;
            out_h_o  <= sc_lines;
            sc_pix   <= 16'd0;
            sc_wid   <= 16'd0;
            sc_lines <= 16'd0;
        end else if (sc_line_end) begin
            if (sc_pix != 16'd0) begin
                sc_wid   <= sc_pix;
                sc_lines <= sat_inc(sc_lines);
            end
            sc_pix <= 16'd0;
        end else if (sc_de_i) begin
            sc_pix <= sat_inc(sc_pix);
        end
    end

    // Watchdog from each passed frame end to the next scaler output frame end; flag is sticky.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_armed     <= 1'b0;
            wd_cnt       <= '0;
            sc_timeout_o <= 1'b0;
        end else begin
            if (cfg_ok) sc_timeout_o <= 1'b0;
            if ((state == RUN) && frame_end) begin
                wd_armed <= 1'b1;
                wd_cnt   <= '0;
            end else if (sc_frame_end) begin
                wd_armed <= 1'b0;
            end else if (wd_armed) begin
                if (wd_cnt == WD_LAST) begin
                    sc_timeout_o <= 1'b1;
                    wd_armed     <= 1'b0;
                end else begin
                    wd_cnt <= wd_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/scaler_frame_ctrl.md
Name: scaler_frame_ctrl

Overview:
Frame-level sequencer in front of the scaler_h -> scaler_v chain. Gates input video so the scalers only ever see whole frames. Applies a new scale_step only at a frame boundary, through a shadow/active register pair. Measures input frame size and scaler output frame size, and flags a missing scaler output frame with a watchdog.

Parameters:
DATA_WIDTH, 8, pixel width in bits
STEP, 4096, unity scale in (4.12) fixed point; reset value of scale_step_o
STEP_MIN, 1024, lowest accepted cfg_step_i (0.25)
STEP_MAX, 16384, highest accepted cfg_step_i (4.0)
TIMEOUT, 1048576, max cycles from end of a passed input frame to scaler output vs rise

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
enable_i  in  1  1 = pass frames; 0 = stop after the current frame
cfg_step_i  in  16  requested scale step, (4.12) unsigned
cfg_wr_i  in  1  one-cycle write strobe for cfg_step_i
cfg_pend_o  out  1  accepted step is waiting for a frame boundary
cfg_err_o  out  1  one-cycle pulse: write rejected (out of range)
scale_step_o  out  16  active step, drives scaler_h/scaler_v scale_step
di_i  in  DATA_WIDTH  input pixel
de_i  in  1  input data enable
hs_i  in  1  input horizontal blank, high = blank
vs_i  in  1  input vertical blank, high = blank
do_o  out  DATA_WIDTH  gated pixel to scaler_h
de_o, hs_o, vs_o  out  1 each  gated timing to scaler_h
sc_de_i, sc_hs_i, sc_vs_i  in  1 each  scaler_v output timing (monitor only)
busy_o  out  1  FSM in RUN
frame_cnt_o  out  16  passed frames, wraps at 0xFFFF -> 0
in_w_o, in_h_o  out  16 each  last passed input frame: pixels in last line, line count
out_w_o, out_h_o  out  16 each  last scaler output frame: same measures
sc_timeout_o  out  1  sticky watchdog flag

Behaviour:
- Reset values: scale_step_o = STEP; de_o = 0; hs_o = 1; vs_o = 1; do_o = 0. All counters, status and flags = 0. FSM = IDLE.
- Edge detection: vs_d, hs_d, sc_vs_d, sc_hs_d are registered copies of the inputs. Frame start = vs_d & ~vs_i. Frame end = ~vs_d & vs_i. Line end = ~hs_d & hs_i.
- FSM states:
  - IDLE -> ARM when enable_i = 1.
  - ARM -> RUN on an input frame start. ARM does not enter RUN mid-frame; it waits for the next vs fall.
  - ARM -> IDLE when enable_i = 0.
  - RUN -> ARM on input frame end if enable_i = 1; RUN -> IDLE on input frame end if enable_i = 0. enable_i is ignored inside RUN.
- Gating: outputs are registered, latency 1 cycle.
  - In RUN, including the frame-start cycle: do_o/de_o/hs_o/vs_o = previous-cycle inputs.
  - Otherwise: de_o = 0, hs_o = 1, vs_o = 1, do_o = 0.
- Config write:
  - On cfg_wr_i, STEP_MIN <= cfg_step_i <= STEP_MAX: shadow <= cfg_step_i and cfg_pend_o <= 1.
  - Otherwise: cfg_err_o pulses 1 cycle; shadow and cfg_pend_o are unchanged.
  - A later write overwrites the shadow (last write wins).
- Apply: on the ARM -> RUN transition, if cfg_pend_o = 1, then scale_step_o <= shadow and cfg_pend_o <= 0. frame_cnt_o increments on every ARM -> RUN.
- Write on the apply cycle: the apply uses the old shadow value. The new value lands in the shadow and cfg_pend_o stays 1.
- Input measurement, active only in RUN:
  - Pixel counter +1 per de_i, cleared at line end.
  - At line end, if the pixel count is nonzero: width register <= count and line counter +1.
  - At input frame end: in_w_o <= width register, in_h_o <= line counter; working counters clear.
- Output measurement: same rules on sc_de_i/sc_hs_i/sc_vs_i. Always active, independent of FSM. Latched into out_w_o/out_h_o on sc_vs rise.
- Watchdog:
  - Armed at each RUN input frame end; counter cleared.
  - Disarmed on sc_vs rise.
  - If armed and the count reaches TIMEOUT: sc_timeout_o <= 1 and the watchdog disarms.
  - sc_timeout_o clears only on rst or on an accepted cfg_wr_i.
- All counters saturate at 0xFFFF except frame_cnt_o, which wraps.
- rst asserted mid-frame: outputs go to blank immediately (async). After release, the FSM passes nothing until a fresh vs fall is seen in ARM.

Test Plan:
- Reset, enable_i = 1, 2 frames of 25x25, DE period 4, vs_i held low at release -> first vs fall passes. de_o count per frame = 625. frame_cnt_o = 2. in_w_o = 25, in_h_o = 25. scale_step_o = 4096.
- Write cfg_step_i = 3686 (0.9) mid-frame -> cfg_pend_o = 1 at once. scale_step_o stays 4096 until the next vs fall, then 3686 the cycle after; cfg_pend_o = 0.
- Write 512, then 20000 -> two cfg_err_o pulses; shadow and scale_step_o unchanged. Write 3686 on the exact frame-start cycle -> old value applied, cfg_pend_o stays 1.
- Enable rises while vs_i = 0 mid-frame -> no de_o until the following vs fall. Deassert enable_i mid-frame -> the current frame passes fully, then hs_o = vs_o = 1, busy_o = 0.
- Hold sc_vs_i low after a passed frame, TIMEOUT = 1000 -> sc_timeout_o = 1 at cycle 1000 after the frame end. A valid cfg write clears it.
- Feed sc_* with 22 lines x 22 pixels -> out_w_o = 22, out_h_o = 22 after sc_vs rise. Assert rst mid-frame -> de_o = 0, hs_o = vs_o = 1 within the same cycle.
